// File: rtl/dispenser_proto_pkg.sv
// rtl/dispenser_proto_pkg.sv - shared constants and helpers for the token-dispenser command protocol
package dispenser_proto_pkg;

    // Verb bytes sent by the initiator
    localparam logic [7:0] V_PING = 8'h02;
    localparam logic [7:0] V_GO   = 8'h06;

    // Response bytes sent by the dispenser controller
    localparam logic [7:0] R_ANNOUNCE = 8'h01;
    localparam logic [7:0] R_PONG     = 8'h05;
    localparam logic [7:0] R_ACCEPT   = 8'h04;
    localparam logic [7:0] R_CONFIRM  = 8'h00;

    // Transaction status codes
    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_TIMEOUT   = 3'd1;
    localparam logic [2:0] ST_BAD_RESP  = 3'd2;
    localparam logic [2:0] ST_DEV_RESET = 3'd3;
    localparam logic [2:0] ST_REJECTED  = 3'd4;

    localparam int FRAME_LEN    = 4;
    localparam int MAX_RESP_LEN = 3;

    localparam logic [1:0] FRAME_LAST = 2'(FRAME_LEN - 1);

    // Which response sequence a verb selects
    typedef enum logic [1:0] {
        K_PING  = 2'd0,
        K_GO    = 2'd1,
        K_OTHER = 2'd2
    } resp_kind_t;

    function automatic resp_kind_t kind_of(input logic [7:0] verb);
        resp_kind_t k;
        case (verb)
            V_PING:  k = K_PING;
            V_GO:    k = K_GO;
            default: k = K_OTHER;
        endcase
        return k;
    endfunction

    // Expected-sequence ROM: GO is accept, verb echo, confirm; unknown verbs
    // make the controller reset and re-announce.
    function automatic logic [7:0] exp_byte(input resp_kind_t k, input logic [1:0] ridx);
        logic [7:0] b;
        b = R_ANNOUNCE;
        case (k)
            K_PING: b = R_PONG;
            K_GO: begin
                case (ridx)
                    2'd0:    b = R_ACCEPT;
                    2'd1:    b = V_GO;
                    default: b = R_CONFIRM;
                endcase
            end
            default: b = R_ANNOUNCE;
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_ridx(input resp_kind_t k);
        return (k == K_GO) ? 2'(MAX_RESP_LEN - 1) : 2'd0;
    endfunction

endpackage

// File: rtl/resp_timer.sv
// rtl/resp_timer.sv - loadable down-counter flagging a response timeout
module resp_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic clk50m,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [31:0] count;

    // Reload to TIMEOUT_CYCLES-1 so that count==0 marks the last allowed cycle
    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else if (load) begin
            count <= TIMEOUT_CYCLES - 32'd1;
        end else if (en && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    assign expired = (count == 32'd0);

endmodule

// File: rtl/cmd_initiator.sv
// rtl/cmd_initiator.sv - sends a 4-byte command frame and checks the controller's reply sequence
module cmd_initiator
    import dispenser_proto_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic       clk50m,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_verb,
    input  logic [7:0] cmd_arg1,
    input  logic [7:0] cmd_arg2,
    input  logic [7:0] cmd_arg3,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       done,
    output logic [2:0] status,
    output logic       dev_announce
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX_ISSUE = 3'd1,
        S_TX_GUARD = 3'd2,
        S_TX_WAIT  = 3'd3,
        S_RX_WAIT  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t     state;
    resp_kind_t kind_q;
    logic [7:0] verb_q, arg1_q, arg2_q, arg3_q;
    logic [1:0] idx, ridx;
    logic [2:0] result;

    logic [7:0] frame_byte;
    logic       rx_match, rx_last;
    logic       timer_load, timer_en, timer_expired;

    // Frame mux and response comparison against the latched expected sequence
    always_comb begin
        frame_byte = verb_q;
        case (idx)
            2'd0:    frame_byte = verb_q;
            2'd1:    frame_byte = arg1_q;
            2'd2:    frame_byte = arg2_q;
            default: frame_byte = arg3_q;
        endcase
        rx_match   = (rx_data == exp_byte(kind_q, ridx));
        rx_last    = (ridx == last_ridx(kind_q));
        timer_load = ((state == S_TX_WAIT) && !tx_busy && (idx == FRAME_LAST)) ||
                     ((state == S_RX_WAIT) && rx_valid && rx_match && !rx_last);
        timer_en   = (state == S_RX_WAIT) && !rx_valid;
    end

    resp_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_resp_timer (
        .clk50m  (clk50m),
        .reset   (reset),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Transaction sequencer with registered handshake and status outputs
    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            kind_q       <= K_PING;
            verb_q       <= 8'h00;
            arg1_q       <= 8'h00;
            arg2_q       <= 8'h00;
            arg3_q       <= 8'h00;
            idx          <= 2'd0;
            ridx         <= 2'd0;
            result       <= ST_OK;
            cmd_ready    <= 1'b0;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            done         <= 1'b0;
            status       <= ST_OK;
            dev_announce <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            done         <= 1'b0;
            dev_announce <= 1'b0;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (rx_valid && (rx_data == R_ANNOUNCE)) begin
                        dev_announce <= 1'b1;
                    end
                    if (cmd_valid && cmd_ready) begin
                        verb_q    <= cmd_verb;
                        arg1_q    <= cmd_arg1;
                        arg2_q    <= cmd_arg2;
                        arg3_q    <= cmd_arg3;
                        kind_q    <= kind_of(cmd_verb);
                        idx       <= 2'd0;
                        cmd_ready <= 1'b0;
                        state     <= S_TX_ISSUE;
                    end
                end
                S_TX_ISSUE: begin
                    tx_data  <= frame_byte;
                    tx_start <= 1'b1;
                    state    <= S_TX_GUARD;
                end
                // The transmitter may not have raised busy yet, so skip one cycle
                S_TX_GUARD: begin
                    state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (!tx_busy) begin
                        if (idx == FRAME_LAST) begin
                            ridx  <= 2'd0;
                            state <= S_RX_WAIT;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= S_TX_ISSUE;
                        end
                    end
                end
                // A byte on the expiry cycle is evaluated before the timeout
                S_RX_WAIT: begin
                    if (rx_valid) begin
                        if (rx_match) begin
                            if (rx_last) begin
                                result <= (kind_q == K_OTHER) ? ST_REJECTED : ST_OK;
                                state  <= S_DONE;
                            end else begin
                                ridx <= ridx + 2'd1;
                            end
                        end else if (rx_data == R_ANNOUNCE) begin
                            result <= ST_DEV_RESET;
                            state  <= S_DONE;
                        end else begin
                            result <= ST_BAD_RESP;
                            state  <= S_DONE;
                        end
                    end else if (timer_expired) begin
                        result <= ST_TIMEOUT;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    status    <= result;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_initiator.sv
// tb/tb_cmd_initiator.sv - vector table and scoreboard bench for cmd_initiator
module tb_cmd_initiator;
    import dispenser_proto_pkg::*;

    localparam logic [31:0] TO = 32'd64;

    logic       clk50m = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_verb, cmd_arg1, cmd_arg2, cmd_arg3;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       done;
    logic [2:0] status;
    logic       dev_announce;

    always #5 clk50m = ~clk50m;

    cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk50m       (clk50m),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_verb     (cmd_verb),
        .cmd_arg1     (cmd_arg1),
        .cmd_arg2     (cmd_arg2),
        .cmd_arg3     (cmd_arg3),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .done         (done),
        .status       (status),
        .dev_announce (dev_announce)
    );

    typedef struct {
        logic [7:0]      verb, a1, a2, a3;
        int              nrep;
        logic [2:0][7:0] rep;
        int              gap;
        logic [2:0]      st;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] exp_tx [$];
    logic [2:0] exp_st [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ann_cnt = 0;
    int busy_left = 0;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Transmitter model (10-cycle busy) plus output scoreboard, all on the falling edge
    always @(negedge clk50m) begin
        cyc++;
        if (!reset) begin
            tx_busy   = 1'b0;
            busy_left = 0;
            prev_done = 1'b0;
        end else begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end
            if (tx_start) begin
                tx_cnt++;
                if (exp_tx.size() == 0) check("unexpected_tx_start", 32'd1, 32'd0);
                else check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                busy_left = 10;
                tx_busy   = 1'b1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_width", 32'(prev_done), 32'd0);
                if (exp_st.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else check("status", 32'(status), 32'(exp_st.pop_front()));
            end
            prev_done = done;
            if (dev_announce) ann_cnt++;
        end
    end

    task automatic step();
        @(negedge clk50m);
        #2;
    endtask

    task automatic set_vec(input int i, input logic [7:0] v, a1, a2, a3, input int n,
                           input logic [7:0] r0, r1, r2, input int gap, input logic [2:0] st);
        vecs[i].verb = v;  vecs[i].a1 = a1; vecs[i].a2 = a2; vecs[i].a3 = a3;
        vecs[i].nrep = n;  vecs[i].rep = {r2, r1, r0};
        vecs[i].gap  = gap; vecs[i].st = st;
    endtask

    task automatic issue_cmd(input vec_t v);
        int n;
        exp_tx.push_back(v.verb); exp_tx.push_back(v.a1);
        exp_tx.push_back(v.a2);   exp_tx.push_back(v.a3);
        exp_st.push_back(v.st);
        step();
        cmd_verb = v.verb; cmd_arg1 = v.a1; cmd_arg2 = v.a2; cmd_arg3 = v.a3;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin step(); n++; end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int base, d0, a0, x, last_rx, n;
        base = tx_cnt; d0 = done_cnt; a0 = ann_cnt;
        issue_cmd(v);
        n = 0;
        while (!(tx_cnt == base + 4 && !tx_busy) && n < 200) begin step(); n++; end
        check("frame_sent", 32'(tx_cnt - base), 32'd4);
        x = cyc;
        last_rx = x;
        for (int j = 0; j < v.nrep; j++) begin
            repeat (v.gap) step();
            rx_data  = v.rep[2'(j)];
            rx_valid = 1'b1;
            last_rx  = cyc;
            step();
            rx_valid = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 300) begin step(); n++; end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        check("tx_starts", 32'(tx_cnt - base), 32'd4);
        if (v.st == ST_TIMEOUT) check("timeout_latency", 32'(done_cyc - x), TO + 32'd2);
        else check("resp_latency", 32'(done_cyc - last_rx), 32'd2);
        check("announce_quiet", 32'(ann_cnt - a0), 32'd0);
        step();
        check("status_hold", 32'(status), 32'(v.st));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},    32'(cmd_ready),    32'd0);
        check({tag, "_tx_start"},     32'(tx_start),     32'd0);
        check({tag, "_tx_data"},      32'(tx_data),      32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_status"},       32'(status),       32'd0);
        check({tag, "_dev_announce"}, 32'(dev_announce), 32'd0);
    endtask

    initial begin
        int base, d0, a0, n;
        reset = 1'b0; cmd_valid = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cmd_verb = 8'h00; cmd_arg1 = 8'h00; cmd_arg2 = 8'h00; cmd_arg3 = 8'h00;

        set_vec(0, V_PING, 8'h00, 8'h00, 8'h00, 1, 8'h05, 8'h00, 8'h00, 3,  ST_OK);
        set_vec(1, V_GO,   8'h03, 8'h01, 8'h02, 3, 8'h04, 8'h06, 8'h00, 20, ST_OK);
        set_vec(2, V_GO,   8'h11, 8'h22, 8'h33, 2, 8'h04, 8'h07, 8'h00, 5,  ST_BAD_RESP);
        set_vec(3, 8'h09,  8'haa, 8'hbb, 8'hcc, 1, 8'h01, 8'h00, 8'h00, 4,  ST_REJECTED);
        set_vec(4, V_PING, 8'h10, 8'h20, 8'h30, 1, 8'h01, 8'h00, 8'h00, 4,  ST_DEV_RESET);
        set_vec(5, V_PING, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1,  ST_TIMEOUT);
        set_vec(6, V_PING, 8'h01, 8'h02, 8'h03, 1, 8'h05, 8'h00, 8'h00, 64, ST_OK);
        set_vec(7, V_PING, 8'h04, 8'h05, 8'h06, 1, 8'h05, 8'h00, 8'h00, 65, ST_TIMEOUT);
        set_vec(8, V_GO,   8'h07, 8'h08, 8'h09, 2, 8'h04, 8'h01, 8'h00, 6,  ST_DEV_RESET);
        set_vec(9, V_GO,   8'hff, 8'hee, 8'hdd, 1, 8'h05, 8'h00, 8'h00, 2,  ST_BAD_RESP);

        // Reset values, then cmd_ready rises right after release
        repeat (3) step();
        check_reset_outputs("rst");
        reset = 1'b1;
        step();
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Announce while idle gives one pulse; other bytes are ignored
        a0 = ann_cnt;
        rx_data = R_ANNOUNCE; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (3) step();
        check("announce_pulse", 32'(ann_cnt - a0), 32'd1);
        rx_data = 8'h05; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (3) step();
        check("announce_other", 32'(ann_cnt - a0), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset during the third tx_start aborts with no repeat and no done
        base = tx_cnt; d0 = done_cnt;
        issue_cmd(vecs[1]);
        n = 0;
        while (tx_cnt != base + 3 && n < 200) begin step(); n++; end
        check("third_start", 32'(tx_cnt - base), 32'd3);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_tx.delete();
        exp_st.delete();
        repeat (3) step();
        reset = 1'b1;
        step();
        check("ready_after_abort", 32'(cmd_ready), 32'd1);
        repeat (40) step();
        check("abort_no_tx", 32'(tx_cnt - base), 32'd3);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
